ptr_alloc_arb: RTL

PTR_ALLOC_ARB -- requirements
Module: ptr_alloc_arb

---
 rtl/ptr_alloc_arb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ptr_alloc_arb.sv
// Free-cell pointer allocator for a shared buffer: round-robin allocation and release
// arbitration, pointer recycling through an external show-ahead FIFO, and double-free detection.
module ptr_alloc_arb #(
    parameter  int NUM_PORTS = 4,
    parameter  int DEPTH     = 8,
    parameter  int LOW_WM    = 2,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS-1:0]       alloc_req,
    output logic [NUM_PORTS-1:0]       alloc_gnt,
    output logic [PTR_W-1:0]           alloc_ptr,
    input  logic [NUM_PORTS-1:0]       rel_req,
    input  logic [NUM_PORTS*PTR_W-1:0] rel_ptr,
    output logic [NUM_PORTS-1:0]       rel_ack,
    output logic                       fifo_rd,
    output logic                       fifo_wr,
    output logic [PTR_W-1:0]           fifo_wdata,
    input  logic [PTR_W-1:0]           fifo_rdata,
    input  logic                       fifo_empty,
    input  logic                       fifo_full,
    output logic [CNT_W-1:0]           free_cnt,
    output logic                       low_wm,
    output logic                       err_dfree
);

    localparam int              RR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [RR_W-1:0] LAST_P   = RR_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LOW_WM_C = CNT_W'(LOW_WM);

    logic [NUM_PORTS-1:0] alloc_gnt_q, alloc_gnt_d;
    logic [PTR_W-1:0]     alloc_ptr_q, alloc_ptr_d;
    logic [NUM_PORTS-1:0] rel_ack_q, rel_ack_d;
    logic [RR_W-1:0]      alloc_rr_q, alloc_rr_d;
    logic [RR_W-1:0]      rel_rr_q, rel_rr_d;
    logic [DEPTH-1:0]     in_use_q, in_use_d;
    logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
    logic                 low_wm_q, low_wm_d;
    logic                 err_q, err_d;

    logic [PTR_W-1:0]     rel_ptr_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0] alloc_elig, rel_elig;
    logic                 alloc_found, rel_found;
    logic [RR_W-1:0]      alloc_win, rel_win;
    logic [PTR_W-1:0]     rel_sel_ptr;
    logic                 rel_valid, pop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rel_unpack
            assign rel_ptr_arr[gi] = rel_ptr[gi*PTR_W +: PTR_W];
        end
    endgenerate

    // A port granted/acked last cycle sits out one cycle so a held level is not double-served.
    assign alloc_elig = alloc_req & ~alloc_gnt_q;
    assign rel_elig   = rel_req & ~rel_ack_q;

    always_comb begin : rr_pick
        int               a_idx;
        int               r_idx;
        logic [RR_W-1:0]  a_sel;
        logic [RR_W-1:0]  r_sel;
        alloc_found = 1'b0;
        alloc_win   = '0;
        rel_found   = 1'b0;
        rel_win     = '0;
        a_idx       = 0;
        r_idx       = 0;
        a_sel       = '0;
        r_sel       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            a_idx = int'(alloc_rr_q) + i;
            if (a_idx >= NUM_PORTS) a_idx = a_idx - NUM_PORTS;
            a_sel = RR_W'(a_idx);
            if (!alloc_found && alloc_elig[a_sel]) begin
                alloc_found = 1'b1;
                alloc_win   = a_sel;
            end
            r_idx = int'(rel_rr_q) + i;
            if (r_idx >= NUM_PORTS) r_idx = r_idx - NUM_PORTS;
            r_sel = RR_W'(r_idx);
            if (!rel_found && rel_elig[r_sel]) begin
                rel_found = 1'b1;
                rel_win   = r_sel;
            end
        end
    end

    assign rel_sel_ptr = rel_ptr_arr[rel_win];
    assign rel_valid   = rel_found && in_use_q[rel_sel_ptr] && !fifo_full;
    assign pop         = alloc_found && !fifo_empty;

    // Strobes are gated by reset so the FIFO, reset alongside, never sees a stray pop/push.
    assign fifo_rd    = rst_n & pop;
    assign fifo_wr    = rst_n & rel_valid;
    assign fifo_wdata = rel_sel_ptr;

    always_comb begin
        alloc_gnt_d = '0;
        alloc_ptr_d = alloc_ptr_q;
        alloc_rr_d  = alloc_rr_q;
        rel_ack_d   = '0;
        rel_rr_d    = rel_rr_q;
        in_use_d    = in_use_q;
        free_cnt_d  = free_cnt_q;
        err_d       = err_q;
        if (pop) begin
            alloc_gnt_d[alloc_win] = 1'b1;
            alloc_ptr_d            = fifo_rdata;
            alloc_rr_d             = (alloc_win == LAST_P) ? '0 : alloc_win + 1'b1;
        end
        if (rel_found) begin
            rel_ack_d[rel_win] = 1'b1;
            rel_rr_d           = (rel_win == LAST_P) ? '0 : rel_win + 1'b1;
            if (!rel_valid) err_d = 1'b1;
        end
        if (rel_valid) in_use_d[rel_sel_ptr] = 1'b0;
        if (pop)       in_use_d[fifo_rdata]  = 1'b1;
        if (pop && !rel_valid && free_cnt_q != '0)
            free_cnt_d = free_cnt_q - 1'b1;
        else if (rel_valid && !pop && free_cnt_q != DEPTH_C)
            free_cnt_d = free_cnt_q + 1'b1;
        low_wm_d = (free_cnt_d <= LOW_WM_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_gnt_q <= '0;
            alloc_ptr_q <= '0;
            rel_ack_q   <= '0;
            alloc_rr_q  <= '0;
            rel_rr_q    <= '0;
            in_use_q    <= '0;
            free_cnt_q  <= DEPTH_C;
            low_wm_q    <= (DEPTH <= LOW_WM);
            err_q       <= 1'b0;
        end else begin
            alloc_gnt_q <= alloc_gnt_d;
            alloc_ptr_q <= alloc_ptr_d;
            rel_ack_q   <= rel_ack_d;
            alloc_rr_q  <= alloc_rr_d;
            rel_rr_q    <= rel_rr_d;
            in_use_q    <= in_use_d;
            free_cnt_q  <= free_cnt_d;
            low_wm_q    <= low_wm_d;
            err_q       <= err_d;
        end
    end

    assign alloc_gnt = alloc_gnt_q;
    assign alloc_ptr = alloc_ptr_q;
    assign rel_ack   = rel_ack_q;
    assign free_cnt  = free_cnt_q;
    assign low_wm    = low_wm_q;
    assign err_dfree = err_q;

endmodule
